// File: rtl/phase_update_scheduler.sv
// Schedules phase-bank updates: takes one focal-position request, runs the phase
// calculator, then commits on the first clock of the next carrier frame.
// Optional BUSY watchdog enabled by defining PHASE_SCHED_TIMEOUT_EN.
module phase_update_scheduler #(
  parameter int POS_BIT_SIZE   = 13,
  parameter int MAX_PHASE_CNT  = 512,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pos_valid,
  output logic                    pos_ready,
  input  logic [POS_BIT_SIZE-1:0] pos_x,
  input  logic [POS_BIT_SIZE-1:0] pos_y,
  input  logic [POS_BIT_SIZE-1:0] pos_z,
  output logic [POS_BIT_SIZE-1:0] calc_x,
  output logic [POS_BIT_SIZE-1:0] calc_y,
  output logic [POS_BIT_SIZE-1:0] calc_z,
  output logic                    calc_start,
  input  logic                    calc_done,
  output logic                    commit,
  output logic                    frame_tick,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int FC_W = (MAX_PHASE_CNT > 1) ? $clog2(MAX_PHASE_CNT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_WAIT_FRAME,
    S_COMMIT
  } state_t;

  state_t                  state_q, state_d;
  logic [FC_W-1:0]         fc_q, fc_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [POS_BIT_SIZE-1:0] pend_x_q, pend_x_d;
  logic [POS_BIT_SIZE-1:0] pend_y_q, pend_y_d;
  logic [POS_BIT_SIZE-1:0] pend_z_q, pend_z_d;
  logic [POS_BIT_SIZE-1:0] calc_x_q, calc_x_d;
  logic [POS_BIT_SIZE-1:0] calc_y_q, calc_y_d;
  logic [POS_BIT_SIZE-1:0] calc_z_q, calc_z_d;

`ifdef PHASE_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_err_q, timeout_err_d;
`endif

  assign frame_tick = (fc_q == FC_W'(MAX_PHASE_CNT - 1));
  assign pos_ready  = ~pend_valid_q;
  assign calc_x     = calc_x_q;
  assign calc_y     = calc_y_q;
  assign calc_z     = calc_z_q;
  assign calc_start = (state_q == S_START);
  assign commit     = (state_q == S_COMMIT);
  assign busy       = (state_q != S_IDLE);

`ifdef PHASE_SCHED_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    fc_d         = frame_tick ? '0 : fc_q + FC_W'(1);
    pend_valid_d = pend_valid_q;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    pend_z_d     = pend_z_q;
    calc_x_d     = calc_x_q;
    calc_y_d     = calc_y_q;
    calc_z_d     = calc_z_q;
`ifdef PHASE_SCHED_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q;
`endif

    // Load and consume are mutually exclusive: load needs the buffer empty at
    // cycle start, IDLE consumes only when it is full.
    if (pos_valid && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_x_d     = pos_x;
      pend_y_d     = pos_y;
      pend_z_d     = pos_z;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_valid_q) begin
          calc_x_d     = pend_x_q;
          calc_y_d     = pend_y_q;
          calc_z_d     = pend_z_q;
          pend_valid_d = 1'b0;
          state_d      = S_START;
        end
      end
      S_START: begin
        state_d = S_BUSY;
`ifdef PHASE_SCHED_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      S_BUSY: begin
        if (calc_done) begin
          state_d = S_WAIT_FRAME;
        end
`ifdef PHASE_SCHED_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      S_WAIT_FRAME: begin
        if (frame_tick) state_d = S_COMMIT;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fc_q         <= '0;
      pend_valid_q <= 1'b0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      pend_z_q     <= '0;
      calc_x_q     <= '0;
      calc_y_q     <= '0;
      calc_z_q     <= '0;
`ifdef PHASE_SCHED_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fc_q         <= fc_d;
      pend_valid_q <= pend_valid_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      pend_z_q     <= pend_z_d;
      calc_x_q     <= calc_x_d;
      calc_y_q     <= calc_y_d;
      calc_z_q     <= calc_z_d;
`ifdef PHASE_SCHED_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_phase_update_scheduler.sv
// Directed bench for phase_update_scheduler: request/start latency, frame-aligned
// commit, buffering/stall, watchdog behaviour and mid-operation reset.
module tb_phase_update_scheduler;

  localparam int PB  = 13;
  localparam int MPC = 512;

  typedef struct packed {
    logic [PB-1:0] x;
    logic [PB-1:0] y;
    logic [PB-1:0] z;
  } pos_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          pos_valid;
  logic          pos_ready;
  logic [PB-1:0] pos_x, pos_y, pos_z;
  logic [PB-1:0] calc_x, calc_y, calc_z;
  logic          calc_start;
  logic          calc_done;
  logic          commit;
  logic          frame_tick;
  logic          busy;
  logic          timeout_err;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   c0    = 0;
  pos_t q[$];

  phase_update_scheduler #(
    .POS_BIT_SIZE  (PB),
    .MAX_PHASE_CNT (MPC),
    .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pos_valid  (pos_valid),
    .pos_ready  (pos_ready),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_z      (pos_z),
    .calc_x     (calc_x),
    .calc_y     (calc_y),
    .calc_z     (calc_z),
    .calc_start (calc_start),
    .calc_done  (calc_done),
    .commit     (commit),
    .frame_tick (frame_tick),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed=stuck expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int fc(input int c);
    return (c - c0) % MPC;
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
    c0 = cyc;
  endtask

  task automatic send(input int x, input int y, input int z, input bit expect_start);
    pos_valid = 1'b1;
    pos_x = PB'(x);
    pos_y = PB'(y);
    pos_z = PB'(z);
    if (expect_start) q.push_back('{x: PB'(x), y: PB'(y), z: PB'(z)});
  endtask

  task automatic wait_start(input string tag, output int at, input int limit);
    pos_t e;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if (calc_start) begin
        at = cyc;
        break;
      end
      step();
    end
    chk({tag, "_seen"}, (at >= 0), 1);
    if (at >= 0 && q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_x"}, calc_x, e.x);
      chk({tag, "_y"}, calc_y, e.y);
      chk({tag, "_z"}, calc_z, e.z);
    end else begin
      chk({tag, "_sb_nonempty"}, q.size(), 1);
    end
  endtask

  task automatic wait_commit(output int at, input int limit);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if (commit) begin
        at = cyc;
        break;
      end
      step();
    end
  endtask

  initial begin
    int s1, s2, s3, s4, t, cm, d, ec, ncommit, nstart, ft, idle_at;
    reset = 1'b1;
    pos_valid = 1'b0;
    calc_done = 1'b0;
    pos_x = '0;
    pos_y = '0;
    pos_z = '0;

    do_reset(3);
    chk("rst_pos_ready", pos_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_calc_start", calc_start, 0);
    chk("rst_commit", commit, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_calc_x", calc_x, 0);
    chk("rst_frame_tick", frame_tick, 0);

    // First request: start exactly two cycles after acceptance
    send(100, 0, 0, 1'b1);
    t = cyc;
    step();
    pos_valid = 1'b0;
    chk("buf_full_rdy", pos_ready, 0);
    wait_start("start1", s1, 10);
    chk("start1_latency", s1 - t, 2);
    step();
    chk("busy_in_calc", busy, 1);
    chk("start_one_cycle", calc_start, 0);

    // Second request held while busy, third stalls
    send(5, 6, 7, 1'b1);
    step();
    send(9, 9, 9, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("third_stalled", pos_ready, 0);
      step();
    end
    pos_valid = 1'b0;

    while (cyc < s1 + 37) step();
    calc_done = 1'b1;
    step();
    calc_done = 1'b0;
    t = s1 + 38;
    while (fc(t) != MPC - 1) t++;
    ec = t + 1;
    wait_commit(cm, 1200);
    chk("commit1_cycle", cm, ec);
    chk("commit1_frame_pos", fc(cm), 0);
    step();
    chk("commit1_one_cycle", commit, 0);
    chk("idle_after_commit", busy, 0);
    wait_start("start2", s2, 5);
    chk("start2_after_commit", s2 - cm, 2);

    // calc_done coincident with frame_tick: commit a full frame later
    step();
    while (fc(cyc) != MPC - 1) step();
    chk("coinc_frame_tick", frame_tick, 1);
    chk("coinc_busy", busy, 1);
    calc_done = 1'b1;
    d = cyc;
    step();
    calc_done = 1'b0;
    chk("no_shortcut", commit, 0);
    wait_commit(cm, 1200);
    chk("commit2_cycle", cm, d + MPC + 1);
    step();

    // calc_done while idle is ignored
    calc_done = 1'b1;
    step();
    calc_done = 1'b0;
    ncommit = 0;
    for (int i = 0; i < 600; i++) begin
      if (commit || busy) ncommit++;
      step();
    end
    chk("idle_done_ignored", ncommit, 0);

    // Calculator never answers
    send(1, 2, 3, 1'b1);
    step();
    pos_valid = 1'b0;
    wait_start("start3", s3, 10);
    ncommit = 0;
    idle_at = -1;
    while (cyc < s3 + 4200) begin
      step();
      if (commit) ncommit++;
      if (!busy && idle_at < 0) idle_at = cyc;
    end
    chk("wd_no_commit", ncommit, 0);
`ifdef PHASE_SCHED_TIMEOUT_EN
    chk("wd_idle_at", idle_at, s3 + 4097);
    chk("wd_timeout_err", timeout_err, 1);
    chk("wd_busy", busy, 0);
`else
    chk("wd_idle_at", idle_at, -1);
    chk("wd_timeout_err", timeout_err, 0);
    chk("wd_busy", busy, 1);
`endif
    do_reset(1);
    chk("wd_rst_busy", busy, 0);
    chk("wd_rst_timeout", timeout_err, 0);

    // Reset during WAIT_FRAME with a pending request
    send(8, 8, 8, 1'b1);
    step();
    pos_valid = 1'b0;
    wait_start("start4", s4, 10);
    step();
    send(4, 4, 4, 1'b0);
    step();
    pos_valid = 1'b0;
    calc_done = 1'b1;
    step();
    calc_done = 1'b0;
    chk("wf_busy", busy, 1);
    chk("wf_pend_full", pos_ready, 0);
    do_reset(1);
    chk("abort_pos_ready", pos_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_commit", commit, 0);
    ncommit = 0;
    nstart = 0;
    ft = -1;
    for (int i = 0; i < 600; i++) begin
      if (commit) ncommit++;
      if (calc_start) nstart++;
      if (frame_tick && ft < 0) ft = cyc;
      step();
    end
    chk("abort_no_commit", ncommit, 0);
    chk("abort_no_start", nstart, 0);
    chk("abort_frame_restart", ft - c0, MPC - 1);
    chk("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
